// File: rtl/mem_access.sv
// Memory stage between ex and wb: latches one instruction, fetches the aligned data word
// for loads and sub-word stores over a req/gnt/rvalid bus, then hands everything to wb.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [31:0]       inst_i,
  input  logic              reg_w_ena_i,
  input  logic [4:0]        reg_w_addr_i,
  input  logic [31:0]       reg_w_data_i,
  input  logic              mem_r_ena_i,
  input  logic              mem_w_ena_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_w_data_i,
  output logic              stall_o,
  output logic              dbus_req_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  output logic              valid_o,
  output logic [31:0]       inst_o,
  output logic              reg_w_ena_o,
  output logic [4:0]        reg_w_addr_o,
  output logic [31:0]       reg_w_data_o,
  output logic              mem_r_ena_o,
  output logic              mem_w_ena_o,
  output logic [ADDR_W-1:0] mem_r_addr_o,
  output logic [DATA_W-1:0] mem_r_data_o,
  output logic [ADDR_W-1:0] mem_w_addr_o,
  output logic [DATA_W-1:0] mem_w_data_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  typedef struct packed {
    logic [31:0]       inst;
    logic              reg_w_ena;
    logic [4:0]        reg_w_addr;
    logic [31:0]       reg_w_data;
    logic              mem_r_ena;
    logic              mem_w_ena;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] w_data;
  } pay_t;

  state_e            state_q, state_d;
  pay_t              cap_q, cap_d, out_q, out_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
  pay_t              in_pay;
  logic              need_rd;

  always_comb begin
    in_pay.inst       = inst_i;
    in_pay.reg_w_ena  = reg_w_ena_i;
    in_pay.reg_w_addr = reg_w_addr_i;
    in_pay.reg_w_data = reg_w_data_i;
    in_pay.mem_r_ena  = mem_r_ena_i;
    in_pay.mem_w_ena  = mem_w_ena_i;
    in_pay.addr       = mem_addr_i;
    in_pay.w_data     = mem_w_data_i;
    need_rd = mem_r_ena_i | (mem_w_ena_i & (inst_i[14:12] != 3'b010));

    state_d    = state_q;
    cap_d      = cap_q;
    out_d      = out_q;
    rdata_d    = rdata_q;
    valid_d    = 1'b0;
    stall_o    = (state_q != IDLE) | (valid_i & need_rd);
    dbus_req_o = (state_q == REQ);

    // Read ops park in cap_q until the word returns, so wb-facing outputs stay
    // held between valid_o pulses.
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (need_rd) begin
            cap_d   = in_pay;
            state_d = REQ;
          end else begin
            out_d   = in_pay;
            rdata_d = '0;
            valid_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (dbus_gnt_i) begin
          if (dbus_rvalid_i) begin
            out_d   = cap_q;
            rdata_d = dbus_rdata_i;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dbus_rvalid_i) begin
          out_d   = cap_q;
          rdata_d = dbus_rdata_i;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      out_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign dbus_addr_o  = {cap_q.addr[ADDR_W-1:2], 2'b00};
  assign valid_o      = valid_q;
  assign inst_o       = out_q.inst;
  assign reg_w_ena_o  = out_q.reg_w_ena;
  assign reg_w_addr_o = out_q.reg_w_addr;
  assign reg_w_data_o = out_q.reg_w_data;
  assign mem_r_ena_o  = out_q.mem_r_ena;
  assign mem_w_ena_o  = out_q.mem_w_ena;
  assign mem_r_addr_o = out_q.addr;
  assign mem_r_data_o = rdata_q;
  assign mem_w_addr_o = out_q.mem_w_ena ? out_q.addr   : '0;
  assign mem_w_data_o = out_q.mem_w_ena ? out_q.w_data : '0;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, LW, SB, SW, bus backpressure, reset mid-read.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] inst_i;
  logic        reg_w_ena_i;
  logic [4:0]  reg_w_addr_i;
  logic [31:0] reg_w_data_i;
  logic        mem_r_ena_i, mem_w_ena_i;
  logic [31:0] mem_addr_i, mem_w_data_i;
  logic        stall_o, dbus_req_o;
  logic [31:0] dbus_addr_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        valid_o;
  logic [31:0] inst_o;
  logic        reg_w_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o;
  logic        mem_r_ena_o, mem_w_ena_o;
  logic [31:0] mem_r_addr_o, mem_r_data_o, mem_w_addr_o, mem_w_data_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD = 32'h0000_0033;
  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_SB  = 32'h0000_0023;
  localparam logic [31:0] I_SW  = 32'h0000_2023;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .inst_i(inst_i),
    .reg_w_ena_i(reg_w_ena_i), .reg_w_addr_i(reg_w_addr_i), .reg_w_data_i(reg_w_data_i),
    .mem_r_ena_i(mem_r_ena_i), .mem_w_ena_i(mem_w_ena_i), .mem_addr_i(mem_addr_i),
    .mem_w_data_i(mem_w_data_i), .stall_o(stall_o), .dbus_req_o(dbus_req_o),
    .dbus_addr_o(dbus_addr_o), .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i(dbus_rdata_i), .valid_o(valid_o), .inst_o(inst_o),
    .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o), .reg_w_data_o(reg_w_data_o),
    .mem_r_ena_o(mem_r_ena_o), .mem_w_ena_o(mem_w_ena_o), .mem_r_addr_o(mem_r_addr_o),
    .mem_r_data_o(mem_r_data_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    valid_i = 0; inst_i = '0; reg_w_ena_i = 0; reg_w_addr_i = '0; reg_w_data_i = '0;
    mem_r_ena_i = 0; mem_w_ena_i = 0; mem_addr_i = '0; mem_w_data_i = '0;
    dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = '0;
  endtask

  task automatic offer(input logic [31:0] inst, input logic rwe, input logic [4:0] rwa,
                       input logic [31:0] rwd, input logic re, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    valid_i = 1; inst_i = inst; reg_w_ena_i = rwe; reg_w_addr_i = rwa; reg_w_data_i = rwd;
    mem_r_ena_i = re; mem_w_ena_i = we; mem_addr_i = addr; mem_w_data_i = wd;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h want 0", stall_o); end
    checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %0h want 0", dbus_req_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", valid_o); end
    checks++; if (mem_r_data_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %0h want 0", mem_r_data_o); end
  endtask

  task automatic test_add();
    step();
    offer(I_ADD, 1, 5'd7, 32'h1234, 0, 0, 32'h0, 32'h0);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL add_stall got %0h want 0", stall_o); end
    step();
    clear_in();
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL add_valid got %0h want 1", valid_o); end
    checks++; if (reg_w_data_o !== 32'h1234) begin errors++; $display("FAIL add_wdata got %0h want 1234", reg_w_data_o); end
    checks++; if (reg_w_addr_o !== 5'd7) begin errors++; $display("FAIL add_waddr got %0h want 7", reg_w_addr_o); end
    checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL add_req got %0h want 0", dbus_req_o); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL add_pulse got %0h want 0", valid_o); end
    checks++; if (reg_w_data_o !== 32'h1234) begin errors++; $display("FAIL add_hold got %0h want 1234", reg_w_data_o); end
  endtask

  task automatic test_load();
    offer(I_LW, 1, 5'd3, 32'h0, 1, 0, 32'h100, 32'h0);
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lw_stall_acc got %0h want 1", stall_o); end
    step();
    clear_in();
    dbus_gnt_i = 1;
    #1;
    checks++; if (dbus_req_o !== 1'b1) begin errors++; $display("FAIL lw_req got %0h want 1", dbus_req_o); end
    checks++; if (dbus_addr_o !== 32'h100) begin errors++; $display("FAIL lw_addr got %0h want 100", dbus_addr_o); end
    step();
    dbus_gnt_i = 0;
    #1;
    checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL lw_req_wait got %0h want 0", dbus_req_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lw_early_valid got %0h want 0", valid_o); end
    step();
    dbus_rvalid_i = 1; dbus_rdata_i = 32'hDEADBEEF;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lw_early_valid2 got %0h want 0", valid_o); end
    step();
    dbus_rvalid_i = 0; dbus_rdata_i = '0;
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL lw_valid got %0h want 1", valid_o); end
    checks++; if (mem_r_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %0h want deadbeef", mem_r_data_o); end
    checks++; if (mem_r_ena_o !== 1'b1) begin errors++; $display("FAIL lw_rena got %0h want 1", mem_r_ena_o); end
    checks++; if (mem_w_addr_o !== 32'h0) begin errors++; $display("FAIL lw_waddr got %0h want 0", mem_w_addr_o); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lw_pulse got %0h want 0", valid_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lw_stall_end got %0h want 0", stall_o); end
    checks++; if (mem_r_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_hold got %0h want deadbeef", mem_r_data_o); end
  endtask

  task automatic test_sb();
    offer(I_SB, 0, 5'd0, 32'h0, 0, 1, 32'h203, 32'hAB);
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL sb_stall got %0h want 1", stall_o); end
    step();
    clear_in();
    dbus_gnt_i = 1; dbus_rvalid_i = 1; dbus_rdata_i = 32'h11223344;
    #1;
    checks++; if (dbus_addr_o !== 32'h200) begin errors++; $display("FAIL sb_addr got %0h want 200", dbus_addr_o); end
    step();
    clear_in();
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL sb_valid got %0h want 1", valid_o); end
    checks++; if (mem_w_addr_o !== 32'h203) begin errors++; $display("FAIL sb_waddr got %0h want 203", mem_w_addr_o); end
    checks++; if (mem_w_data_o !== 32'hAB) begin errors++; $display("FAIL sb_wdata got %0h want ab", mem_w_data_o); end
    checks++; if (mem_r_addr_o !== 32'h203) begin errors++; $display("FAIL sb_raddr got %0h want 203", mem_r_addr_o); end
    checks++; if (mem_r_data_o !== 32'h11223344) begin errors++; $display("FAIL sb_rdata got %0h want 11223344", mem_r_data_o); end
    step();
  endtask

  task automatic test_sw();
    offer(I_SW, 0, 5'd0, 32'h0, 0, 1, 32'h40, 32'h5555);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL sw_stall got %0h want 0", stall_o); end
    checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL sw_req got %0h want 0", dbus_req_o); end
    step();
    clear_in();
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL sw_valid got %0h want 1", valid_o); end
    checks++; if (mem_r_data_o !== 32'h0) begin errors++; $display("FAIL sw_rdata got %0h want 0", mem_r_data_o); end
    checks++; if (mem_w_addr_o !== 32'h40) begin errors++; $display("FAIL sw_waddr got %0h want 40", mem_w_addr_o); end
    checks++; if (mem_w_data_o !== 32'h5555) begin errors++; $display("FAIL sw_wdata got %0h want 5555", mem_w_data_o); end
    checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL sw_req2 got %0h want 0", dbus_req_o); end
    step();
  endtask

  task automatic test_back_to_back();
    offer(I_LW, 1, 5'd9, 32'h0, 1, 0, 32'h3C6, 32'h0);
    step();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({dbus_req_o, stall_o} !== 2'b11) begin errors++; $display("FAIL bp_req_stall%0d got %b want 11", i, {dbus_req_o, stall_o}); end
      checks++; if (dbus_addr_o !== 32'h3C4) begin errors++; $display("FAIL bp_addr%0d got %0h want 3c4", i, dbus_addr_o); end
      step();
    end
    dbus_gnt_i = 1; dbus_rvalid_i = 1; dbus_rdata_i = 32'hCAFE0001;
    step();
    clear_in();
    offer(I_ADD, 1, 5'd4, 32'h77, 0, 0, 32'h0, 32'h0);
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_done_valid got %0h want 1", valid_o); end
    checks++; if (mem_r_data_o !== 32'hCAFE0001) begin errors++; $display("FAIL bp_rdata got %0h want cafe0001", mem_r_data_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL bp_done_stall got %0h want 1", stall_o); end
    step();
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_add_early got %0h want 0", valid_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL bp_add_stall got %0h want 0", stall_o); end
    step();
    clear_in();
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_add_valid got %0h want 1", valid_o); end
    checks++; if (reg_w_data_o !== 32'h77) begin errors++; $display("FAIL bp_add_data got %0h want 77", reg_w_data_o); end
    checks++; if (mem_r_data_o !== 32'h0) begin errors++; $display("FAIL bp_add_rdata got %0h want 0", mem_r_data_o); end
    step();
  endtask

  task automatic test_reset_in_wait();
    offer(I_LW, 1, 5'd2, 32'h0, 1, 0, 32'h80, 32'h0);
    step();
    clear_in();
    dbus_gnt_i = 1;
    step();
    dbus_gnt_i = 0;
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++; if ({stall_o, dbus_req_o, valid_o} !== 3'b000) begin errors++; $display("FAIL rw_ctrl got %b want 000", {stall_o, dbus_req_o, valid_o}); end
    checks++; if (dbus_addr_o !== 32'h0) begin errors++; $display("FAIL rw_addr got %0h want 0", dbus_addr_o); end
    checks++; if (reg_w_data_o !== 32'h0) begin errors++; $display("FAIL rw_wdata got %0h want 0", reg_w_data_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rw_inst got %0h want 0", inst_o); end
    dbus_rvalid_i = 1; dbus_rdata_i = 32'h12345678;
    step();
    dbus_rvalid_i = 0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rw_stray got %0h want 0", valid_o); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rw_stray2 got %0h want 0", valid_o); end
    checks++; if (mem_r_data_o !== 32'h0) begin errors++; $display("FAIL rw_rdata got %0h want 0", mem_r_data_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_sb();
    test_sw();
    test_back_to_back();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
